store_unit: RTL and testbench
=============================

# store_unit

Memory-write back end for decoded RISC-V S-type instructions (SB/SH/SW). Takes the source register values, 12-bit immediate and store_control (funct3) produced by the store decoder, forms the effective address, and generates a byte-lane-aligned write. It drives that write to the data memory over a req/gnt/ack handshake and reports completion or a fault to the pipeline. It sits between execute and the data-memory port.

## Interface

- TIMEOUT_CYCLES, 255: maximum number of cycles spent in REQ+WAIT_ACK before a timeout fault; legal range 2..65535.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from execute.
- st_ready  out  1  unit idle; a request is accepted on st_valid && st_ready.
- rs1_data  in  32  base register value.
- rs2_data  in  32  store data register value.
- imm  in  12  S-type immediate; sign-extended to 32 bits.
- store_control  in  3  funct3: 000 SB, 001 SH, 010 SW; all other codes are illegal.
- mem_req  out  1  write request.
- mem_addr  out  32  word address; bits [1:0] are always 00.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  memory accepted the request.
- mem_ack  in  1  write committed.
- st_done  out  1  one-cycle pulse on successful completion.
- st_fault  out  1  one-cycle pulse on fault.
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; valid only with st_fault, 00 otherwise.
- fault_addr  out  32  effective address of the faulting store; valid only with st_fault.

## Operation

- **States:** IDLE, REQ, WAIT_ACK, DONE, FAULT. st_ready = (state == IDLE).
- **Accept (IDLE):** on accept, register the effective address ea = rs1_data + sext(imm), mod 2^32 (wrap, no overflow flag).
- **Next state from IDLE, in priority order:**
  - illegal funct3 -> FAULT (cause 10);
  - SH with ea[0] = 1, or SW with ea[1:0] != 00 -> FAULT (cause 01);
  - otherwise -> REQ.
- **Lane rules** (registered at accept, held stable until leaving WAIT_ACK):
  - SB: mem_be = 0001 << ea[1:0]; mem_wdata = {4{rs2_data[7:0]}}.
  - SH: mem_be = 0011 if ea[1] = 0, else 1100; mem_wdata = {2{rs2_data[15:0]}}.
  - SW: mem_be = 1111; mem_wdata = rs2_data.
  - mem_addr = {ea[31:2], 2'b00}.
- **REQ:** mem_req = 1 and is held with stable address/data/be until mem_gnt.
  - mem_gnt && mem_ack in the same cycle -> DONE.
  - mem_gnt alone -> WAIT_ACK.
  - mem_ack without mem_gnt is ignored.
- **WAIT_ACK:** mem_req = 0; mem_ack -> DONE.
- **DONE:** st_done = 1 for one cycle -> IDLE.
- **FAULT:** st_fault = 1 for one cycle, with fault_cause and fault_addr = ea -> IDLE.
- **Timeout:**
  - The counter clears on accept and increments every cycle spent in REQ or WAIT_ACK.
  - If the TIMEOUT_CYCLES-th such cycle ends without a transition to DONE -> FAULT (cause 11). mem_req is deasserted in the FAULT cycle.
  - An ack/gnt completion on that final cycle wins over the timeout.
- mem_gnt and mem_ack are ignored in IDLE, DONE and FAULT.

## Timing

- **Reset values:** state IDLE; st_ready 1; mem_req 0; mem_addr, mem_wdata, mem_be 0; st_done 0; st_fault 0; fault_cause 00; fault_addr 0.
- **Reset mid-transaction:** asserting rst_n low drops mem_req asynchronously. No st_done or st_fault is produced for the abandoned store.
- **Latency:** request accepted at edge 0; mem_req high in cycle 1.
  - Best case (gnt+ack in cycle 1): st_done in cycle 2; st_ready high again in cycle 3.
  - gnt in cycle 1, ack in cycle k: st_done in cycle k+1.
  - Fault on accept: st_fault in cycle 1; st_ready in cycle 2.
- **Throughput:** at most one store in flight. No new request is accepted until the state returns to IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from mem_gnt or mem_ack to any output.

## Test plan

- **SW, aligned:** rs1 = 0x1000, imm = 0x004, rs2 = 0xDEADBEEF, 010; gnt+ack in cycle 1 -> mem_addr 0x1004, be 1111, wdata 0xDEADBEEF; st_done in cycle 2.
- **SB with negative immediate:** rs1 = 0x2003, imm = 0xFFF (-1), rs2 = 0x000000A5, 000 -> ea 0x2002, mem_addr 0x2000, be 0100, wdata 0xA5A5A5A5.
- **Misaligned SH / illegal funct3:**
  - SH at ea 0x3001 -> st_fault cycle 1, cause 01, fault_addr 0x3001; mem_req never asserted.
  - funct3 = 011 -> cause 10.
- **Handshake stalls:** gnt held low 3 cycles, then ack 4 cycles after gnt -> mem_req/addr/be stable throughout REQ; mem_req low in WAIT_ACK; exactly one st_done pulse.
- **Timeout:** TIMEOUT_CYCLES = 4, gnt never asserted -> st_fault cycle 5, cause 11, mem_req low in the FAULT cycle. Repeat with ack on the 4th cycle -> st_done, no fault.
- **Reset mid-transaction:** rst_n pulsed low during WAIT_ACK -> mem_req 0 and st_ready 1 immediately; no done/fault pulse. A following SW completes normally.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: RISC-V SB/SH/SW write back end with req/gnt/ack memory handshake
// Ports:
//   clk, rst_n                            clock and async active-low reset
//   st_valid/st_ready                     store request from execute / unit idle
//   rs1_data, rs2_data, imm, store_control  decoded S-type operands and funct3
//   mem_req/addr/wdata/be, mem_gnt/ack    data-memory write port
//   st_done, st_fault, fault_cause/addr   one-cycle completion and fault reports
module store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [11:0] imm,
  input  logic [2:0]  store_control,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
  localparam logic [15:0] LAST   = 16'(TIMEOUT_CYCLES - 1);
  logic [2:0]  state_q, state_d;
  logic [31:0] ea_q, ea_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] ea;
  logic        illegal, misal, expired;
  always_comb begin
    ea      = rs1_data + {{20{imm[11]}}, imm};
    illegal = store_control[2] || (store_control[1:0] == 2'b11);
    misal   = (store_control == 3'b001 && ea[0]) || (store_control == 3'b010 && ea[1:0] != 2'b00);
    // cnt_q counts REQ/WAIT_ACK cycles already completed, so this is the last allowed one
    expired = (cnt_q == LAST);
    state_d = state_q;
    ea_d    = ea_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (st_valid) begin
        ea_d    = ea;
        cnt_d   = 16'd0;
        cause_d = illegal ? 2'b10 : misal ? 2'b01 : 2'b00;
        state_d = (illegal || misal) ? S_FAULT : S_REQ;
        be_d    = store_control == 3'b000 ? 4'b0001 << ea[1:0] :
                  store_control == 3'b001 ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_d = store_control == 3'b000 ? {4{rs2_data[7:0]}} :
                  store_control == 3'b001 ? {2{rs2_data[15:0]}} : rs2_data;
      end
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_gnt && mem_ack) state_d = S_DONE;
        else if (expired) begin
          state_d = S_FAULT;
          cause_d = 2'b11;
        end else if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_ack) state_d = S_DONE;
        else if (expired) begin
          state_d = S_FAULT;
          cause_d = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ea_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end
  assign st_ready    = state_q == S_IDLE;
  assign mem_req     = state_q == S_REQ;
  assign mem_addr    = {ea_q[31:2], 2'b00};
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign st_done     = state_q == S_DONE;
  assign st_fault    = state_q == S_FAULT;
  assign fault_cause = st_fault ? cause_q : 2'b00;
  assign fault_addr  = st_fault ? ea_q : 32'd0;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: table-driven and sequence checks for store_unit
module tb_store_unit;
  logic clk = 0, rst_n = 0;
  logic st_valid_a = 0, st_valid_b = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic [11:0] imm = 0;
  logic [2:0] ctl = 0;
  logic gnt = 0, ack = 0;
  logic ready_a, req_a, done_a, fault_a, ready_b, req_b, done_b, fault_b;
  logic [31:0] addr_a, wdata_a, faddr_a, addr_b, wdata_b, faddr_b;
  logic [3:0] be_a, be_b;
  logic [1:0] cause_a, cause_b;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  store_unit u_a (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid_a), .st_ready(ready_a),
    .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .store_control(ctl),
    .mem_req(req_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_be(be_a),
    .mem_gnt(gnt), .mem_ack(ack), .st_done(done_a), .st_fault(fault_a),
    .fault_cause(cause_a), .fault_addr(faddr_a)
  );

  store_unit #(.TIMEOUT_CYCLES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid_b), .st_ready(ready_b),
    .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .store_control(ctl),
    .mem_req(req_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_be(be_b),
    .mem_gnt(gnt), .mem_ack(ack), .st_done(done_b), .st_fault(fault_b),
    .fault_cause(cause_b), .fault_addr(faddr_b)
  );

  typedef struct {
    logic [31:0] rs1, rs2;
    logic [11:0] imm;
    logic [2:0]  ctl;
    logic        flt;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Best-case handshake: gnt+ack offered in cycle 1; fault vectors never reach REQ.
  task automatic run_vec(input vec_t v, input int idx);
    rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; ctl = v.ctl;
    st_valid_a = 1; gnt = 1; ack = 1;
    step();
    st_valid_a = 0;
    if (v.flt) begin
      chk($sformatf("v%0d fault", idx), fault_a, 1);
      chk($sformatf("v%0d cause", idx), cause_a, v.cause);
      chk($sformatf("v%0d faddr", idx), faddr_a, v.addr);
      chk($sformatf("v%0d noreq", idx), req_a, 0);
      step();
      chk($sformatf("v%0d ready2", idx), ready_a, 1);
      chk($sformatf("v%0d fault_once", idx), fault_a, 0);
    end else begin
      chk($sformatf("v%0d req", idx), req_a, 1);
      chk($sformatf("v%0d addr", idx), addr_a, v.addr);
      chk($sformatf("v%0d be", idx), be_a, v.be);
      chk($sformatf("v%0d wdata", idx), wdata_a, v.wdata);
      chk($sformatf("v%0d cause0", idx), cause_a, 0);
      step();
      chk($sformatf("v%0d done", idx), done_a, 1);
      chk($sformatf("v%0d req_off", idx), req_a, 0);
      step();
      chk($sformatf("v%0d ready3", idx), ready_a, 1);
      chk($sformatf("v%0d done_once", idx), done_a, 0);
    end
    gnt = 0; ack = 0;
  endtask

  // Instance with TIMEOUT_CYCLES=4: gc/ac are the cycles carrying gnt/ack (0 = never).
  task automatic run_to(input int gc, input int ac, input logic exp_done, input string nm);
    rs1 = 32'h0000A000; imm = 12'h000; ctl = 3'b010; rs2 = 32'h55AA55AA;
    st_valid_b = 1; gnt = 0; ack = 0;
    step();
    st_valid_b = 0;
    for (int c = 1; c <= 4; c++) begin
      gnt = (c == gc); ack = (c == ac);
      chk({nm, " req"}, req_b, (gc == 0 || c <= gc) ? 1 : 0);
      chk({nm, " quiet"}, {done_b, fault_b}, 0);
      step();
    end
    gnt = 0; ack = 0;
    chk({nm, " done"}, done_b, exp_done);
    chk({nm, " fault"}, fault_b, !exp_done);
    chk({nm, " cause"}, cause_b, exp_done ? 2'b00 : 2'b11);
    chk({nm, " faddr"}, faddr_b, exp_done ? 32'h0 : 32'h0000A000);
    chk({nm, " req_low"}, req_b, 0);
    step();
    chk({nm, " ready"}, ready_b, 1);
  endtask

  initial begin
    vt[0] = '{32'h00001000, 32'hDEADBEEF, 12'h004, 3'b010, 1'b0, 2'b00, 32'h00001004, 4'b1111, 32'hDEADBEEF};
    vt[1] = '{32'h00002003, 32'h000000A5, 12'hFFF, 3'b000, 1'b0, 2'b00, 32'h00002000, 4'b0100, 32'hA5A5A5A5};
    vt[2] = '{32'h00003000, 32'h0000BEEF, 12'h001, 3'b001, 1'b1, 2'b01, 32'h00003001, 4'b0000, 32'h0};
    vt[3] = '{32'h00004000, 32'h00000000, 12'h000, 3'b011, 1'b1, 2'b10, 32'h00004000, 4'b0000, 32'h0};
    vt[4] = '{32'h00005000, 32'h12345678, 12'h002, 3'b001, 1'b0, 2'b00, 32'h00005000, 4'b1100, 32'h56785678};
    vt[5] = '{32'hFFFFFFFF, 32'h000001C3, 12'h002, 3'b000, 1'b0, 2'b00, 32'h00000000, 4'b0010, 32'hC3C3C3C3};
    vt[6] = '{32'h00006000, 32'h00000000, 12'h002, 3'b010, 1'b1, 2'b01, 32'h00006002, 4'b0000, 32'h0};
    vt[7] = '{32'h00007001, 32'h00000000, 12'h000, 3'b101, 1'b1, 2'b10, 32'h00007001, 4'b0000, 32'h0};
    vt[8] = '{32'h00008000, 32'hAAAABBBB, 12'h800, 3'b001, 1'b0, 2'b00, 32'h00007800, 4'b0011, 32'hBBBBBBBB};
    vt[9] = '{32'h00000100, 32'h0BADF00D, 12'hFFC, 3'b010, 1'b0, 2'b00, 32'h000000FC, 4'b1111, 32'h0BADF00D};

    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", ready_a, 1);
    chk("rst req", req_a, 0);
    chk("rst addr", addr_a, 0);
    chk("rst wdata", wdata_a, 0);
    chk("rst be", be_a, 0);
    chk("rst done/fault", {done_a, fault_a}, 0);
    chk("rst cause", cause_a, 0);
    chk("rst faddr", faddr_a, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Stall: gnt in cycle 4, ack only in cycle 8; stray ack in cycle 2 without gnt.
    rs1 = 32'h00009000; imm = 12'h000; rs2 = 32'h11223344; ctl = 3'b010;
    st_valid_a = 1;
    step();
    st_valid_a = 0;
    rs1 = 32'h0; rs2 = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      gnt = (c == 4); ack = (c == 2 || c == 8);
      chk($sformatf("stall req c%0d", c), req_a, c <= 4 ? 1 : 0);
      chk($sformatf("stall addr c%0d", c), addr_a, 32'h00009000);
      chk($sformatf("stall be c%0d", c), be_a, 4'b1111);
      chk($sformatf("stall wdata c%0d", c), wdata_a, 32'h11223344);
      chk($sformatf("stall quiet c%0d", c), {done_a, fault_a}, 0);
      step();
    end
    gnt = 0; ack = 0;
    chk("stall done", done_a, 1);
    step();
    chk("stall done_once", done_a, 0);
    chk("stall ready", ready_a, 1);

    run_to(0, 0, 1'b0, "timeout");
    run_to(1, 4, 1'b1, "ack_last");
    run_to(4, 4, 1'b1, "gntack_last");

    // Reset while waiting for ack.
    rs1 = 32'h0000B000; imm = 12'h000; rs2 = 32'h77777777; ctl = 3'b010;
    st_valid_a = 1; gnt = 1; ack = 0;
    step();
    st_valid_a = 0;
    step();
    gnt = 0;
    chk("mid wait req", req_a, 0);
    chk("mid busy", ready_a, 0);
    #2 rst_n = 0;
    #1;
    chk("mid rst ready", ready_a, 1);
    chk("mid rst req", req_a, 0);
    #1 rst_n = 1;
    ack = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("post rst quiet%0d", c), {done_a, fault_a}, 0);
    end
    ack = 0;
    run_vec(vt[0], 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
